// File: rtl/vga_display_param.sv
// Parameterised VGA timing generator with a two-stage pixel pipeline.
// Pixels come from an external fetch port or an internal 8-bar colour pattern.
module vga_display_param #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 30,
  parameter int CLK_DIV    = 2,
  parameter int COLOR_BITS = 1,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP,
  localparam int H_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int V_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pattern_en,
  output logic                    pix_req,
  output logic [H_W-1:0]          pix_x,
  output logic [V_W-1:0]          pix_y,
  input  logic [3*COLOR_BITS-1:0] pix_data,
  output logic                    vga_hsync,
  output logic                    vga_vsync,
  output logic [COLOR_BITS-1:0]   vga_r,
  output logic [COLOR_BITS-1:0]   vga_g,
  output logic [COLOR_BITS-1:0]   vga_b,
  output logic                    frame_start,
  output logic                    line_start
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HE_W  = H_W + 1;
  localparam int VE_W  = V_W + 1;
  localparam int HB_W  = H_W + 3;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [H_W-1:0]   H_LAST     = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
  localparam logic [HE_W-1:0]  H_VIS_END  = HE_W'(H_VISIBLE);
  localparam logic [HE_W-1:0]  H_SYNC_BEG = HE_W'(H_VISIBLE + H_FP);
  localparam logic [HE_W-1:0]  H_SYNC_END = HE_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VE_W-1:0]  V_VIS_END  = VE_W'(V_VISIBLE);
  localparam logic [VE_W-1:0]  V_SYNC_BEG = VE_W'(V_VISIBLE + V_FP);
  localparam logic [VE_W-1:0]  V_SYNC_END = VE_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [HB_W-1:0]  BAR_DEN    = HB_W'(H_VISIBLE);

  function automatic logic [3*COLOR_BITS-1:0] bar_rgb(input logic [2:0] bar);
    bar_rgb = {{COLOR_BITS{bar[2]}}, {COLOR_BITS{bar[1]}}, {COLOR_BITS{bar[0]}}};
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             pix_ce;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             mode_pat;

  logic             at_origin;
  logic             visible;
  logic             hs_act;
  logic             vs_act;
  logic             pattern_act;
  logic [HB_W-1:0]  h_x8;
  logic [2:0]       bar;

  logic             vld_p0;
  logic             vis_p0;
  logic             pat_p0;
  logic [2:0]       bar_p0;
  logic             hsync_p0;
  logic             vsync_p0;
  logic [3*COLOR_BITS-1:0] rgb_p1;

  // rst is released synchronously to clk by the system reset controller,
  // so every register below leaves reset on the same edge.
  assign pix_ce = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (pix_ce) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign visible   = ({1'b0, h_cnt} < H_VIS_END) && ({1'b0, v_cnt} < V_VIS_END);
  assign hs_act    = ({1'b0, h_cnt} >= H_SYNC_BEG) && ({1'b0, h_cnt} < H_SYNC_END);
  assign vs_act    = ({1'b0, v_cnt} >= V_SYNC_BEG) && ({1'b0, v_cnt} < V_SYNC_END);
  assign h_x8      = {h_cnt, 3'b000};
  assign bar       = 3'(h_x8 / BAR_DEN);

  // The origin pixel already belongs to the new frame, so it sees pattern_en
  // directly; every later pixel of the frame uses the latched mode.
  assign pattern_act = (pix_ce && at_origin) ? pattern_en : mode_pat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_pat <= 1'b0;
    end else if (pix_ce && at_origin) begin
      mode_pat <= pattern_en;
    end
  end

  assign pix_req     = rst & pix_ce & visible & ~pattern_act;
  assign pix_x       = h_cnt;
  assign pix_y       = v_cnt;
  assign frame_start = rst & pix_ce & at_origin;
  assign line_start  = rst & pix_ce & (h_cnt == '0);

  // Stage 0: capture position attributes on the pixel strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p0   <= 1'b0;
      vis_p0   <= 1'b0;
      pat_p0   <= 1'b0;
      bar_p0   <= '0;
      hsync_p0 <= ~HSYNC_POL;
      vsync_p0 <= ~VSYNC_POL;
    end else begin
      vld_p0 <= pix_ce;
      if (pix_ce) begin
        vis_p0   <= visible;
        pat_p0   <= pattern_act;
        bar_p0   <= bar;
        hsync_p0 <= hs_act ? HSYNC_POL : ~HSYNC_POL;
        vsync_p0 <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      end
    end
  end

  always_comb begin
    rgb_p1 = '0;
    if (vis_p0) begin
      rgb_p1 = pat_p0 ? bar_rgb(bar_p0) : pix_data;
    end
  end

  // Stage 1: colour sampled one clk after the fetch, drives the pins
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_hsync <= ~HSYNC_POL;
      vga_vsync <= ~VSYNC_POL;
      vga_r     <= '0;
      vga_g     <= '0;
      vga_b     <= '0;
    end else if (vld_p0) begin
      vga_hsync <= hsync_p0;
      vga_vsync <= vsync_p0;
      {vga_r, vga_g, vga_b} <= rgb_p1;
    end
  end

endmodule

// File: doc/vga_display_param.md
VGA_DISPLAY_PARAM -- requirements
Module: vga_display_param

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP, H_SYNC, H_BP, defaults 16, 96, 48, horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP, V_SYNC, V_BP, defaults 10, 5, 30, vertical front porch, sync and back porch in lines.
REQ-005 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel; legal values are 1 or greater.
REQ-006 SHALL have parameter COLOR_BITS, default 1, bits per colour channel.
REQ-007 SHALL have parameters HSYNC_POL and VSYNC_POL, default 0 each, giving the active sync level.
REQ-008 SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-010 SHALL have port pattern_en, input, 1 bit, selecting the internal colour-bar pattern instead of pix_data.
REQ-011 SHALL have port pix_req, output, 1 bit, a pixel fetch strobe.
REQ-012 SHALL have ports pix_x and pix_y, outputs, clog2(H_TOTAL) and clog2(V_TOTAL) bits, the fetch coordinates.
REQ-013 SHALL have port pix_data, input, 3*COLOR_BITS bits, ordered {r,g,b}.
REQ-014 SHALL have ports vga_hsync and vga_vsync, outputs, 1 bit each.
REQ-015 SHALL have ports vga_r, vga_g and vga_b, outputs, COLOR_BITS each.
REQ-016 SHALL have ports frame_start and line_start, outputs, 1 bit each, single-clk status pulses.

Function
REQ-017 H_TOTAL SHALL equal H_VISIBLE+H_FP+H_SYNC+H_BP, and V_TOTAL SHALL be formed likewise from the vertical parameters.
REQ-018 Divider div_cnt SHALL count 0..CLK_DIV-1 and wrap; pix_ce SHALL be 1 on the cycle div_cnt==CLK_DIV-1; with CLK_DIV=1, pix_ce SHALL be constantly 1.
REQ-019 h_cnt SHALL advance only on pix_ce, wrapping H_TOTAL-1 -> 0; v_cnt SHALL advance only on pix_ce with h_cnt==H_TOTAL-1, wrapping V_TOTAL-1 -> 0.
REQ-020 The position is visible when h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
REQ-021 hsync SHALL be active for h_cnt in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC), and vsync for v_cnt in the equivalent vertical window; otherwise both are at !POL.
REQ-022 pix_req SHALL be 1 for exactly the pix_ce cycle of a visible position when the active mode is external; pix_x and pix_y SHALL equal h_cnt and v_cnt on that cycle.
REQ-023 The pixel source SHALL present pix_data on the clk cycle after pix_req; the block samples it only then, and the fetch has no back-pressure.
REQ-024 The active mode SHALL be latched from pattern_en only on the pix_ce cycle with h_cnt==0 and v_cnt==0; a mid-frame change SHALL take effect next frame.
REQ-025 In pattern mode, bar = (h_cnt*8)/H_VISIBLE (0..7), and each channel SHALL be all ones when bar bit 2, 1 or 0 is set (r, g and b respectively), else zero; pix_req SHALL stay 0.
REQ-026 The pipeline SHALL be two stages: on cycle N (pix_ce) it captures position P; on cycle N+1 it samples colour; vga_* SHALL show P from the rising edge ending cycle N+1 until the next update.
REQ-027 hsync and vsync SHALL be delayed through the same two stages, so sync and colour stay aligned.
REQ-028 vga_r, vga_g and vga_b SHALL be 0 for every non-visible position, whatever pix_data holds.
REQ-029 frame_start SHALL pulse for 1 clk on the pix_ce with h==0, v==0, and line_start SHALL pulse for 1 clk on each pix_ce with h==0; both are aligned to stage 0, not the output.
REQ-030 Arithmetic SHALL be unsigned, the bar multiply SHALL be sized to avoid overflow, and the counters SHALL never exceed their TOTAL-1.

Reset
REQ-031 While rst==0, div_cnt, h_cnt, v_cnt and the pipeline SHALL be 0, the active mode external, pix_req, frame_start, line_start and RGB 0, and syncs at !POL.
REQ-032 Deassertion SHALL be synchronous to clk; the first pix_ce SHALL occur CLK_DIV cycles after release, with frame_start on it.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no partial-line completion.

Verification
REQ-034 Small timing H=8/1/2/1, V=4/1/1/1, CLK_DIV=1, POL=0 -> hsync low for h 9..10, vsync low on v=5, frame period 12*7=84 clk, one frame_start per 84.
REQ-035 CLK_DIV=3 -> pix_req spacing 3 clk, frame period 252 clk, pix_x sequence 0..7 then none until the next line.
REQ-036 External mode with pix_data = pix_x low bits -> vga_{r,g,b} equals the fetched value exactly 2 clk after pix_req, and 0 in blanking.
REQ-037 pattern_en=1 raised mid-frame -> pix_req continues until the next frame_start, then pix_req==0 and bars read 0,1,...,7 across x=0..7 for H_VISIBLE=8, COLOR_BITS=2 (bar 5 -> r=3, g=0, b=3).
REQ-038 rst pulsed low at h=5, v=2 -> outputs at reset values within the same cycle; after release, frame_start appears on the first pix_ce.
REQ-039 HSYNC_POL=VSYNC_POL=1 -> syncs idle low, active high, windows as REQ-034.
